wide_addsub_pipe: RTL and testbench



---
 rtl/wide_addsub_pipe.sv | 134 +++++++++++++
 tb/tb_wide_addsub_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wide_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wide_addsub_pipe
// Purpose  : Pipelined ripple-carry adder/subtractor. A WIDTH-bit operation is
//            split into STAGES = WIDTH/CHUNK slices. Each stage adds one
//            CHUNK-bit slice and passes its carry forward through a register,
//            so a new result can be produced every advancing cycle.
// Ports    : clk       - clock, all state updates on the rising edge
//            reset     - synchronous active-high reset, priority over en
//            en        - pipeline advance; 0 freezes every register
//            in_valid  - a/b/cin/sub carry a transaction this cycle
//            a, b      - operands (unsigned or two's complement)
//            cin       - carry-in for add, borrow-in for subtract
//            sub       - 0: a + b + cin, 1: a - b - cin
//            out_valid - sum/cout/ovf hold a new result this cycle
//            sum       - result modulo 2^WIDTH
//            cout      - raw carry out of the MSB (for subtract, 1 = no borrow)
//            ovf       - signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module wide_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_chunk_safe = (CHUNK < 1) ? 1 : CHUNK;
    localparam int STAGES       = WIDTH / c_chunk_safe;

    if ((CHUNK < 1) || ((WIDTH % c_chunk_safe) != 0)) begin : g_bad_params
        $error("wide_addsub_pipe: WIDTH must be a positive multiple of CHUNK");
    end

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    // Stage k sees the operand bits [WIDTH-1:k*CHUNK] still to be added, the
    // carry out of the slices below it and the sum bits already produced.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_rem = WIDTH - k * CHUNK;

        logic [c_rem-1:0]         w_a;
        logic [c_rem-1:0]         w_b;
        logic                     w_cin;
        logic                     w_valid;
        logic [CHUNK:0]           w_chunk;
        logic [(k+1)*CHUNK-1:0]   w_sum_acc;

        if (k == 0) begin : g_src
            // Subtraction folds into addition: a + ~b + ~cin == a - b - cin.
            assign w_a       = a;
            assign w_b       = sub ? ~b : b;
            assign w_cin     = sub ? ~cin : cin;
            assign w_valid   = in_valid;
            assign w_sum_acc = w_chunk[CHUNK-1:0];
        end else begin : g_src
            assign w_a       = g_stage[k-1].g_mid.r_a;
            assign w_b       = g_stage[k-1].g_mid.r_b;
            assign w_cin     = g_stage[k-1].g_mid.r_carry;
            assign w_valid   = g_stage[k-1].g_mid.r_valid;
            assign w_sum_acc = {w_chunk[CHUNK-1:0], g_stage[k-1].g_mid.r_sum};
        end

        assign w_chunk = {1'b0, w_a[CHUNK-1:0]} + {1'b0, w_b[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, w_cin};

        if (k < STAGES - 1) begin : g_mid
            logic [(k+1)*CHUNK-1:0] r_sum;
            logic                   r_carry;
            logic [c_rem-CHUNK-1:0] r_a;
            logic [c_rem-CHUNK-1:0] r_b;
            logic                   r_valid;

            // Only the valid bit needs clearing; data behind a cleared valid
            // is never observed.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid <= 1'b0;
                end else if (en) begin
                    r_valid <= w_valid;
                    r_sum   <= w_sum_acc;
                    r_carry <= w_chunk[CHUNK];
                    r_a     <= w_a[c_rem-1:CHUNK];
                    r_b     <= w_b[c_rem-1:CHUNK];
                end
            end
        end else begin : g_last
            logic w_ovf;

            // Carry into the MSB equals a^b'^sum at that bit, so overflow is
            // carry-out XOR that recovered carry-in.
            assign w_ovf = w_chunk[CHUNK] ^ w_a[CHUNK-1] ^ w_b[CHUNK-1]
                         ^ w_chunk[CHUNK-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_out_valid <= 1'b0;
                    r_sum       <= '0;
                    r_cout      <= 1'b0;
                    r_ovf       <= 1'b0;
                end else if (en) begin
                    r_out_valid <= w_valid;
                    // Bubbles leave the last result on the outputs.
                    if (w_valid) begin
                        r_sum  <= w_sum_acc;
                        r_cout <= w_chunk[CHUNK];
                        r_ovf  <= w_ovf;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wide_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_wide_addsub_pipe
// Purpose  : Self-checking bench for wide_addsub_pipe (WIDTH=16, CHUNK=4).
//            Expected results come from signed/unsigned integer arithmetic and
//            an arrival schedule counted in advancing edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wide_addsub_pipe;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int STAGES = WIDTH / CHUNK;

    logic             clk;
    logic             reset;
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    wide_addsub_pipe #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [17:0] res;   // {cout, ovf, sum}
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          adv   = 0;
    logic [17:0] last_res = '0;
    logic        last_ov  = 1'b0;

    // Reference arithmetic straight from the integer definition of the op.
    function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                           input logic c, input logic s);
        int ux, uy, sx, sy, ur, sr;
        logic co, ov;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!s) begin
            ur = ux + uy + int'(c);
            co = (ur > 65535);
            sr = sx + sy + int'(c);
        end else begin
            ur = ux - uy - int'(c);
            co = (ux >= uy + int'(c));
            sr = sx - sy - int'(c);
        end
        ov = (sr > 32767) || (sr < -32768);
        return {co, ov, 16'(ur)};
    endfunction

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, take the edge, then check against the model.
    task automatic step(input logic r, input logic e, input logic v,
                        input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic is,
                        input bit has_lit, input logic [17:0] lit);
        exp_t        t;
        logic [17:0] want;
        reset    = r;
        en       = e;
        in_valid = v;
        a        = ia;
        b        = ib;
        cin      = ic;
        sub      = is;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            last_res = '0;
            last_ov  = 1'b0;
            chk("reset_out_valid", {17'd0, out_valid}, 18'd0);
            chk("reset_result", {cout, ovf, sum}, 18'd0);
        end else if (!e) begin
            chk("stall_out_valid", {17'd0, out_valid}, {17'd0, last_ov});
            chk("stall_result", {cout, ovf, sum}, last_res);
        end else begin
            adv++;
            if (v) begin
                t.due = adv + STAGES - 1;
                t.res = has_lit ? lit : ref_op(ia, ib, ic, is);
                q.push_back(t);
            end
            if (q.size() > 0 && q[0].due == adv) begin
                want = q[0].res;
                q.pop_front();
                chk("out_valid_high", {17'd0, out_valid}, 18'd1);
                chk("result", {cout, ovf, sum}, want);
                last_res = want;
                last_ov  = 1'b1;
            end else begin
                chk("out_valid_low", {17'd0, out_valid}, 18'd0);
                chk("hold_result", {cout, ovf, sum}, last_res);
                last_ov = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 18'h0);
    endtask

    task automatic send(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic is);
        step(1'b0, 1'b1, 1'b1, ia, ib, ic, is, 1'b0, 18'h0);
    endtask

    // Directed vector with its result written out by hand.
    task automatic send_lit(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                            input logic is, input logic [15:0] s, input logic co, input logic ov);
        step(1'b0, 1'b1, 1'b1, ia, ib, ic, is, 1'b1, {co, ov, s});
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic r, e, v;
        // Reset state.
        step(1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 18'h0);
        step(1'b1, 1'b0, 1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1, 1'b0, 18'h0);
        idle(2);

        // Directed boundary vectors, back to back.
        send_lit(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_lit(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_lit(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send_lit(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send_lit(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
        send_lit(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        idle(STAGES + 1);

        // Streaming with one bubble at n=10 and a 3-cycle stall at n=25.
        for (int n = 0; n < 40; n++) begin
            if (n == 10) idle(1);
            if (n == 25) begin
                for (int s = 0; s < 3; s++)
                    step(1'b0, 1'b0, 1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b1, 1'b0, 18'h0);
            end
            send_lit(16'(200 + n), 16'(n), 1'b0, 1'b0, 16'(200 + 2 * n), 1'b0, 1'b0);
        end
        idle(STAGES + 1);

        // Reset with three transactions in flight, then one fresh transaction.
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b1, 1'b1);
        send(16'h5555, 16'h6666, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0, 18'h0);
        send_lit(16'h0100, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0);
        idle(STAGES + 1);

        // Randomized traffic with random stalls, bubbles and rare resets.
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 4) != 0);
            step(r, e, v, pick_operand(), pick_operand(), 1'($urandom), 1'($urandom),
                 1'b0, 18'h0);
        end

        idle(STAGES + 2);
        chk("drain_empty", 18'(q.size()), 18'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
